// File: rtl/store_queue_unit_if.sv
// Store-request and data-memory handshake bundle for the store queue.
// master drives requests and mem_ready; slave is the queue itself.
interface store_queue_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_base;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_size;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  modport master (
    output in_valid, in_base, in_imm, in_data, in_size, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  in_valid, in_base, in_imm, in_data, in_size, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_queue_unit.sv
// Store stage: effective-address/legality check, lane formation, and a
// DEPTH-entry FIFO draining to data memory over valid/ready.
module store_queue_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  store_queue_unit_if.slave      sq,
  input  logic                   flush,
  output logic                   err,
  output logic [ADDR_W-1:0]      err_addr,
  output logic [$clog2(DEPTH):0] count
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ea;
  logic [3:0]        nbytes;
  logic              size_err;
  logic              align_err;
  logic              legal;
  logic              accept;
  logic              push;
  logic              pop;
  int                nb_eff;
  logic [BE_W-1:0]   lane_mask;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [ADDR_W-1:0] lane_addr;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];

  assign ea        = sq.in_base + {{(ADDR_W-IMM_W){sq.in_imm[IMM_W-1]}}, sq.in_imm};
  assign nbytes    = 4'd1 << sq.in_size;
  assign size_err  = 32'(nbytes) > BE_W;
  assign align_err = |(ea[2:0] & (nbytes[2:0] - 3'd1));
  assign legal     = !size_err && !align_err;

  assign sq.in_ready  = count < CNT_W'(DEPTH);
  assign sq.mem_valid = count != '0;
  assign accept       = sq.in_valid && sq.in_ready;
  assign push         = accept && legal && !flush;
  assign pop          = sq.mem_valid && sq.mem_ready;

  // Lane mask wraps to all-ones when the access covers the full bus width.
  assign nb_eff    = size_err ? BE_W : 32'(nbytes);
  assign lane_mask = (BE_W'(1) << nbytes) - BE_W'(1);
  assign lane_be   = lane_mask << ea[OFF_W-1:0];
  assign lane_addr = {ea[ADDR_W-1:OFF_W], OFF_W'(0)};

  always_comb begin
    lane_wdata = '0;
    for (int i = 0; i < BE_W; i++) begin
      lane_wdata[8*i +: 8] = sq.in_data[8*(i & (nb_eff - 1)) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= lane_addr;
      data_mem[wr_ptr] <= lane_wdata;
      be_mem[wr_ptr]   <= lane_be;
    end
  end

  assign sq.mem_addr  = addr_mem[rd_ptr];
  assign sq.mem_wdata = data_mem[rd_ptr];
  assign sq.mem_be    = be_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal) err_addr <= ea;
      if (flush) begin
        // Keep only an in-flight head; a same-cycle pop still retires it.
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= sq.mem_valid ? rd_ptr + PTR_W'(1) : rd_ptr;
        count  <= (sq.mem_valid && !pop) ? CNT_W'(1) : '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end
endmodule
